inv_key_expand: RTL and testbench

Iterative AES-128 round-key generator for the decryption datapath, the key-side counterpart of the encryption engine's per-round key add. It accepts a cipher key and runs the forward key schedule to round key 10. It then streams round keys in reverse order, 10 down to 0, using the inverse key schedule. Output is one key per handshake to the inverse-round pipeline, which consumes them as its AddRoundKey operands.

---
 rtl/aes_dec_pkg.sv | 67 ++++++
 rtl/key_word_sub.sv | 31 +++
 rtl/inv_key_expand.sv | 168 ++++++++++++++++
 tb/tb_inv_key_expand.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_pkg
// Description : Shared definitions for the AES-128 decryption key path:
//               round count, round-constant lookup, key-expander state
//               encoding and the AES S-box function.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

    // Round constant (top byte of Rcon word) for rounds 1..10.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (as v^254, which maps 0 to 0) followed
    // by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = v;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_word_sub.sv
`default_nettype none
// ============================================================================
// Module      : key_word_sub
// Description : Key-schedule word function SubWord(RotWord(w)) ^ Rcon.
//               Four parallel S-boxes, purely combinational.
// Ports       : i_word  - 32-bit key word (MSB = byte 0)
//               i_rcon  - round constant, XORed into the top byte
//               o_word  - transformed word
// Revision    : 1.0 - initial release
// ============================================================================
module key_word_sub
    import aes_dec_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [7:0]  i_rcon,
    output logic [31:0] o_word
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign w_rot = {i_word[23:0], i_word[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub[8*g +: 8] = sbox(w_rot[8*g +: 8]);
    end

    assign o_word = w_sub ^ {i_rcon, 24'h000000};

endmodule
`default_nettype wire

// File: rtl/inv_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : inv_key_expand
// Description : Iterative AES-128 round-key generator for decryption. Runs the
//               forward schedule to round key 10, then streams round keys
//               10..0 using the inverse schedule, one per handshake.
// Ports       : clk, rst (async, active-low)
//               key_valid/key_ready/key_in  - cipher key input handshake
//               rk_valid/rk_ready/rk_out    - round key output handshake
//               rk_idx  - round number of rk_out; rk_last - final key flag
//               busy    - block is not idle
// Config      : KEY_CACHE_EN - caches last cipher key and its round-10 key so
//               a repeated key skips the forward schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_key_expand
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:127] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_out,
    output logic [0:3]   rk_idx,
    output logic         rk_last,
    output logic         busy
);

    localparam logic [3:0] c_RND_MAX      = 4'(NUM_ROUNDS);
    localparam logic [3:0] c_RND_FWD_LAST = 4'(NUM_ROUNDS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [0:127]   r_kreg;
    logic [0:127]   w_kreg_nxt;
    logic [3:0]     r_rnd;
    logic [3:0]     w_rnd_nxt;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_inv3;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [7:0]     w_rcon;
    logic [31:0]    w_f0, w_f1, w_f2, w_f3;
    logic [0:127]   w_fwd;
    logic [0:127]   w_inv;

    assign w_w0 = r_kreg[0:31];
    assign w_w1 = r_kreg[32:63];
    assign w_w2 = r_kreg[64:95];
    assign w_w3 = r_kreg[96:127];

    // Inverse step recovers w3 first; the shared word function then works on
    // the recovered w3 (REV) or the current w3 (FWD).
    assign w_inv3   = w_w3 ^ w_w2;
    assign w_sub_in = (r_state == REV) ? w_inv3 : w_w3;
    // FWD produces round rnd+1; REV undoes round rnd.
    assign w_rcon   = rcon((r_state == REV) ? r_rnd : (r_rnd + 4'd1));

    key_word_sub u_key_word_sub (
        .i_word (w_sub_in),
        .i_rcon (w_rcon),
        .o_word (w_sub_out)
    );

    assign w_f0  = w_w0 ^ w_sub_out;
    assign w_f1  = w_w1 ^ w_f0;
    assign w_f2  = w_w2 ^ w_f1;
    assign w_f3  = w_w3 ^ w_f2;
    assign w_fwd = {w_f0, w_f1, w_f2, w_f3};
    assign w_inv = {w_w0 ^ w_sub_out, w_w1 ^ w_w0, w_w2 ^ w_w1, w_inv3};

`ifdef KEY_CACHE_EN
    logic         r_cache_vld;
    logic [0:127] r_cache_key;
    logic [0:127] r_cache_rk10;
    logic [0:127] r_cur_key;
    logic         w_hit;

    assign w_hit = r_cache_vld && (key_in == r_cache_key);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cache_vld  <= 1'b0;
            r_cache_key  <= '0;
            r_cache_rk10 <= '0;
            r_cur_key    <= '0;
        end else begin
            if (r_state == IDLE && key_valid) begin
                r_cur_key <= key_in;
            end
            if (r_state == FWD && r_rnd == c_RND_FWD_LAST) begin
                r_cache_key  <= r_cur_key;
                r_cache_rk10 <= w_fwd;
                r_cache_vld  <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_kreg  <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kreg  <= w_kreg_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kreg_nxt  = r_kreg;
        w_rnd_nxt   = r_rnd;
        unique case (r_state)
            IDLE: begin
                if (key_valid) begin
`ifdef KEY_CACHE_EN
                    if (w_hit) begin
                        w_kreg_nxt  = r_cache_rk10;
                        w_rnd_nxt   = c_RND_MAX;
                        w_state_nxt = REV;
                    end else
`endif
                    begin
                        w_kreg_nxt  = key_in;
                        w_rnd_nxt   = 4'd0;
                        w_state_nxt = FWD;
                    end
                end
            end
            FWD: begin
                w_kreg_nxt = w_fwd;
                w_rnd_nxt  = r_rnd + 4'd1;
                if (r_rnd == c_RND_FWD_LAST) begin
                    w_state_nxt = REV;
                end
            end
            REV: begin
                if (rk_ready) begin
                    if (r_rnd == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_kreg_nxt = w_inv;
                        w_rnd_nxt  = r_rnd - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign key_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rk_valid  = (r_state == REV);
    assign rk_last   = (r_state == REV) && (r_rnd == 4'd0);
    assign rk_out    = r_kreg;
    assign rk_idx    = r_rnd;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_expand.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_key_expand
// Description : Self-checking bench for inv_key_expand. A table-driven
//               FIPS-197 key expansion model fills a scoreboard with the
//               expected reverse stream; a monitor pops on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] rk_out;
    logic [0:3]   rk_idx;
    logic         rk_last;
    logic         busy;

    inv_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] m_rk [0:10];
    logic [127:0] got  [0:10];
    int           checks = 0;
    int           errors = 0;
    int           hs_cnt = 0;
    bit           rand_ready = 1'b0;
    bit           cache_v = 1'b0;
    logic [127:0] cache_key = '0;

    task automatic chk(input string name, input bit ok, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        logic [31:0] s;
        r = {w[23:0], w[31:24]};
        for (int b = 0; b < 4; b++) begin
            s[8*b +: 8] = SBOX[(255 - int'(r[8*b +: 8])) * 8 +: 8];
        end
        return s;
    endfunction

    // Standard 44-word key expansion; round key r is words 4r..4r+3.
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_rot(t) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // rk_ready driver: constant 1 or pseudo-random.
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: stall stability and scoreboard pops on handshakes.
    initial begin
        bit           prev_stall;
        logic [127:0] prev_out;
        logic [3:0]   prev_idx;
        exp_t         e;
        prev_stall = 1'b0;
        prev_out   = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", rk_valid == 1'b1, 128'(rk_valid), 128'd1);
                    chk("stall_key", rk_out == prev_out, rk_out, prev_out);
                    chk("stall_idx", rk_idx == prev_idx, 128'(rk_idx), 128'(prev_idx));
                end
                if (rk_valid && rk_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_key", 1'b0, rk_out, '0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rk_out", rk_out == e.key, rk_out, e.key);
                        chk("rk_idx", rk_idx == e.idx, 128'(rk_idx), 128'(e.idx));
                        chk("rk_last", rk_last == (e.idx == 4'd0), 128'(rk_last),
                            128'(e.idx == 4'd0));
                        got[e.idx] = rk_out;
                        hs_cnt++;
                    end
                end
                prev_stall = rk_valid && !rk_ready;
                prev_out   = rk_out;
                prev_idx   = rk_idx;
            end
        end
    end

    // Offer a key until accepted; expected stream is queued at acceptance.
    task automatic send_key(input logic [127:0] k, output bit acc);
        acc = 1'b0;
        model_expand(k);
        key_valid = 1'b1;
        key_in    = k;
        for (int n = 0; n < 60 && !acc; n++) begin
            @(negedge clk);
            if (key_ready) begin
                acc = 1'b1;
                for (int r = 10; r >= 0; r--) sb_q.push_back({m_rk[r], 4'(r)});
            end
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        chk("key_accept", acc, 128'(acc), 128'd1);
    endtask

    task automatic run_key(input logic [127:0] k, input bit pulse);
        bit acc;
        int lat;
        int tot;
        int hs0;
        int lat_exp;
        bit hit;
        hit = 1'b0;
`ifdef KEY_CACHE_EN
        hit = cache_v && (cache_key == k);
`endif
        lat_exp = hit ? 0 : 10;
        hs0 = hs_cnt;
        send_key(k, acc);
        lat = 0;
        while (!rk_valid && lat < 40) begin
            if (pulse && lat == 3) begin
                chk("busy_fwd_ready", key_ready == 1'b0, 128'(key_ready), 128'd0);
                key_valid = 1'b1;
                key_in    = ~k;
            end
            if (lat == 4) key_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        key_valid = 1'b0;
        chk("first_latency", lat == lat_exp, 128'(lat), 128'(lat_exp));
        chk("first_rk", rk_out == m_rk[10], rk_out, m_rk[10]);
        chk("first_idx", rk_idx == 4'd10, 128'(rk_idx), 128'd10);
        chk("busy_high", busy == 1'b1, 128'(busy), 128'd1);
        if (!hit) begin
            cache_v   = 1'b1;
            cache_key = k;
        end
        tot = lat;
        while (!key_ready && tot < 500) begin
            if (pulse && tot == lat + 2) begin
                chk("busy_rev_ready", key_ready == 1'b0, 128'(key_ready), 128'd0);
                key_valid = 1'b1;
                key_in    = ~k;
            end
            if (tot == lat + 3) key_valid = 1'b0;
            @(posedge clk);
            #1;
            tot++;
        end
        key_valid = 1'b0;
        chk("stream_done", key_ready == 1'b1, 128'(key_ready), 128'd1);
        if (!rand_ready) chk("total_cycles", tot == lat + 11, 128'(tot), 128'(lat + 11));
        chk("handshakes", hs_cnt - hs0 == 11, 128'(hs_cnt - hs0), 128'd11);
        chk("sb_empty", sb_q.size() == 0, 128'(sb_q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_key_ready", key_ready == 1'b1, 128'(key_ready), 128'd1);
        chk("rst_rk_valid", rk_valid == 1'b0, 128'(rk_valid), 128'd0);
        chk("rst_rk_out", rk_out == '0, rk_out, '0);
        chk("rst_rk_idx", rk_idx == 4'd0, 128'(rk_idx), 128'd0);
        chk("rst_rk_last", rk_last == 1'b0, 128'(rk_last), 128'd0);
        chk("rst_busy", busy == 1'b0, 128'(busy), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        int           n;
        logic [127:0] k;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 key, free-running consumer
        run_key(FIPS_KEY, 1'b0);
        chk("fips_rk10", got[10] == FIPS_RK10, got[10], FIPS_RK10);
        chk("fips_rk1", got[1] == FIPS_RK1, got[1], FIPS_RK1);
        chk("fips_rk0", got[0] == FIPS_KEY, got[0], FIPS_KEY);

        // All-zero key
        run_key('0, 1'b0);
        chk("zero_rk10", got[10] == ZERO_RK10, got[10], ZERO_RK10);
        chk("zero_rk0", got[0] == '0, got[0], '0);

        // Backpressure with busy rejection pulses
        rand_ready = 1'b1;
        run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        run_key(FIPS_KEY, 1'b1);
        run_key(FIPS_KEY, 1'b1);
        chk("bp_fips_rk1", got[1] == FIPS_RK1, got[1], FIPS_RK1);

        // Reset mid-stream at rk_idx 5
        rand_ready = 1'b0;
        send_key(FIPS_KEY, acc);
        n = 0;
        while (!(rk_valid && rk_idx == 4'd5) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_idx5", rk_valid && rk_idx == 4'd5, 128'(rk_idx), 128'd5);
        rst = 1'b0;
        sb_q.delete();
        cache_v = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_key(FIPS_KEY, 1'b0);
        chk("post_rst_rk0", got[0] == FIPS_KEY, got[0], FIPS_KEY);

        // Randomized keys and consumer behaviour
        for (int i = 0; i < 4; i++) begin
            rand_ready = 1'($urandom_range(0, 1));
            k = {$urandom, $urandom, $urandom, $urandom};
            run_key(k, 1'($urandom_range(0, 1)));
            chk("rand_rk0", got[0] == k, got[0], k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
